// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants, FSM state type and width default for
//               the bit-serial ALU sequencer and its 1-bit slice.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operations whose final carry is reported on cout.
  function automatic logic op_has_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Operations whose signed overflow is reported.
  function automatic logic op_has_ovf(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_top.sv
`default_nettype none
// ============================================================================
// Module      : alu_top
// Description : 1-bit ALU slice. Optional inversion of both inputs, then
//               AND / OR / full-add / less selection by opcode. Invalid
//               opcodes return 0. checktop is a registered copy of the raw
//               adder sum for debug observation of the top bit.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_top
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       src1,
  input  logic       src2,
  input  logic       less,
  input  logic       A_invert,
  input  logic       B_invert,
  input  logic       cin,
  input  logic [2:0] operation,
  output logic       result,
  output logic       cout,
  output logic       checktop
);

  logic w_a;
  logic w_b;
  logic w_sum;

  assign w_a   = src1 ^ A_invert;
  assign w_b   = src2 ^ B_invert;
  assign w_sum = w_a ^ w_b ^ cin;
  assign cout  = (w_a & w_b) | (w_a & cin) | (w_b & cin);

  // Result select; NOR reuses the AND path with both inputs inverted.
  always_comb begin
    result = 1'b0;
    case (operation)
      OP_AND, OP_NOR: result = w_a & w_b;
      OP_OR:          result = w_a | w_b;
      OP_ADD, OP_SUB: result = w_sum;
      OP_SLT:         result = less;
      default:        result = 1'b0;
    endcase
  end

  // Debug tap of the adder sum, one cycle late.
  always_ff @(posedge clk) begin
    checktop <= w_sum;
  end

endmodule
`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_ctrl
// Description : Bit-serial sequencer running a WIDTH-bit ALU operation through
//               one alu_top slice, LSB first, one bit per clock. Reports the
//               result with zero, cout and overflow flags and a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;

  logic             w_last;
  logic             w_a_inv;
  logic             w_b_inv;
  logic             w_slice_res;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_shifted;
  logic             w_msb_ovf;
  logic             w_slt_set;
  logic [WIDTH-1:0] w_final;

  assign w_last = (r_cnt == C_LAST);

  // Subtraction-style ops invert B; NOR inverts both so the AND path gives ~a & ~b.
  assign w_a_inv = (r_op == OP_NOR);
  assign w_b_inv = (r_op == OP_SUB) || (r_op == OP_SLT) || (r_op == OP_NOR);

  alu_top u_slice (
    .clk       (clk),
    .src1      (r_a[0]),
    .src2      (r_b[0]),
    .less      (1'b0),
    .A_invert  (w_a_inv),
    .B_invert  (w_b_inv),
    .cin       (r_carry),
    .operation (r_op),
    .result    (w_slice_res),
    .cout      (w_slice_cout),
    .checktop  ()
  );

  // Result assembly on the last bit: SLT takes the corrected sign of a-b.
  always_comb begin
    w_shifted = {w_slice_res, result[WIDTH-1:1]};
    w_msb_ovf = r_carry ^ w_slice_cout;
    w_slt_set = (r_a[0] ^ ~r_b[0] ^ r_carry) ^ w_msb_ovf;
    w_final   = w_shifted;
    if (r_op == OP_SLT) begin
      w_final = {{(WIDTH-1){1'b0}}, w_slt_set};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand shift registers, carry flop, bit counter and result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= src1;
            r_b     <= src2;
            r_op    <= operation;
            r_cnt   <= '0;
            r_carry <= (operation == OP_SUB) || (operation == OP_SLT);
            result  <= '0;
          end
        end
        ST_RUN: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_slice_cout;
          if (w_last) begin
            result   <= w_final;
            zero     <= (w_final == '0);
            cout     <= op_has_carry(r_op) ? w_slice_cout : 1'b0;
            overflow <= op_has_ovf(r_op) ? w_msb_ovf : 1'b0;
          end else begin
            result <= w_shifted;
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_ctrl
// Description : Scoreboard bench for alu_serial_ctrl: directed and random
//               operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_ctrl;

  localparam int WIDTH = 32;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    int          acc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  operation = 3'b000;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        overflow;

  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operation (operation),
    .src1      (src1),
    .src2      (src2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to measure accept-to-done latency.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model from signed/unsigned arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    longint sa, sb_, s;
    logic [32:0] u;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    e.res = '0; e.c = 1'b0; e.v = 1'b0;
    case (op)
      3'b001: e.res = a & b;
      3'b010: e.res = a | b;
      3'b101: e.res = ~(a | b);
      3'b011: begin
        u = {1'b0, a} + {1'b0, b};
        e.res = u[31:0];
        e.c = u[32];
        s = sa + sb_;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b100: begin
        e.res = a - b;
        e.c = (a >= b);
        s = sa - sb_;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110: begin
        e.res = (sa < sb_) ? 32'd1 : 32'd0;
        e.c = (a >= b);
      end
      default: ;
    endcase
    e.z = (e.res == 32'd0);
  endtask

  // Waits for IDLE, presents one request for a cycle and records its expectation.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string nm);
    exp_t e;
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk({nm, "_idle_timeout"}, 32'd1, 32'd0);
    model(op, a, b, e);
    e.acc = edge_cnt + 1;
    e.name = nm;
    sb.push_back(e);
    start = 1'b1;
    operation = op;
    src1 = a;
    src2 = b;
    @(negedge clk);
    start = 1'b0;
    src1 = $urandom;
    src2 = $urandom;
  endtask

  // Monitor: on each done pulse pop and compare against the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
      chk("busy_in_done", {31'd0, busy}, 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.z});
        chk({e.name, "_cout"}, {31'd0, cout}, {31'd0, e.c});
        chk({e.name, "_ovf"}, {31'd0, overflow}, {31'd0, e.v});
        // done lands in the (WIDTH+1)th cycle after acceptance, i.e. after edge E+WIDTH.
        chk({e.name, "_latency"}, 32'(edge_cnt - e.acc), 32'(WIDTH));
      end
    end
    prev_done = done;
  end

  initial begin
    int t;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'b011, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap");
    issue(3'b100, 32'h8000_0000, 32'h0000_0001, "sub_ovf");
    issue(3'b110, 32'hFFFF_FFFB, 32'h0000_0003, "slt_neg");
    issue(3'b110, 32'h7FFF_FFFF, 32'h8000_0000, "slt_ovf");
    issue(3'b001, 32'hF0F0_00FF, 32'h0FF0_F00F, "and");
    issue(3'b010, 32'hF0F0_00FF, 32'h0FF0_F00F, "or");
    issue(3'b101, 32'hF0F0_00FF, 32'h0FF0_F00F, "nor");
    issue(3'b000, 32'hDEAD_BEEF, 32'h1234_5678, "inv000");
    issue(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "inv111");

    // start during RUN cycle 5 must be ignored.
    issue(3'b011, 32'h1111_1111, 32'h2222_2222, "add_ignore");
    repeat (4) @(negedge clk);
    start = 1'b1;
    operation = 3'b100;
    src1 = 32'hAAAA_AAAA;
    src2 = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;

    // Reset at RUN cycle 10 aborts with no done.
    issue(3'b011, 32'h1234_5678, 32'h0000_0001, "add_abort");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd1);
    void'(sb.pop_back());
    issue(3'b011, 32'd3, 32'd4, "add_after_rst");

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = ra;
      if (i % 7 == 0) ra = 32'h8000_0000;
      issue(rop, ra, rb, "rand");
    end

    t = 0;
    while ((sb.size() != 0 || busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
